// File: rtl/shift_left_seq.sv
// shift_left_seq: multi-cycle logical left shifter, one bit position per clock
module shift_left_seq #(
  parameter int n = 16,
  parameter int m = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] in,
  input  logic [m-1:0] shift,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic         carry
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [m-1:0] count;
  logic accept;
  assign accept = start && state != SHIFT;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  // next state: a zero shift skips straight to DONE, otherwise count down to the final shift
  always_comb begin
    state_nx = IDLE;
    if (accept) state_nx = shift == '0 ? DONE : SHIFT;
    else if (state == SHIFT) state_nx = count == m'(1) ? DONE : SHIFT;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // datapath: capture on accept, shift one bit per SHIFT cycle, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      result <= in;
      carry  <= 1'b0;
      count  <= shift;
    end else if (state == SHIFT) begin
      result <= {result[n-2:0], 1'b0};
      carry  <= result[n-1];
      count  <= count - m'(1);
    end
  end
endmodule

// File: doc/shift_left_seq.md
# shift_left_seq

Sequential logical left shifter. It is the left-direction counterpart of the combinational right shifter in the CPU datapath. It accepts an N-bit operand and an M-bit shift amount on a start pulse, then shifts one bit position per clock. It reports the result, the last bit shifted out (carry) and a one-cycle done pulse. The ALU sequencer uses it where a multi-cycle shift is acceptable in place of a barrel shifter.

## Interface
Parameters:
- n, 16, operand/result width
- m, 4, shift-amount width (max shift 2^m-1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled on rising edge, accepted only when not busy
- in  input  n  operand, captured on accepted start
- shift  input  m  shift amount, captured on accepted start
- busy  output  1  high while shifting (state SHIFT)
- done  output  1  one-cycle pulse, result/carry valid
- result  output  n  shifted value, held until next accepted start
- carry  output  1  last bit shifted out of MSB; 0 when shift=0

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- Reset values: busy=0, done=0, result=0, carry=0, internal count=0.
- Accept: start=1 on an edge while in IDLE or DONE. On that edge (E0), data<=in, carry<=0, count<=shift.
  - shift=0: go to DONE; result=in.
  - shift≥1: go to SHIFT.
- SHIFT, each edge: carry<=data[n-1], data<=data<<1 with LSB filled with 0, count<=count-1. When count==1 at the edge, perform the final shift and go to DONE.
- DONE lasts one cycle. Without start, go to IDLE. With start, accept (back-to-back) as above.
- start while in SHIFT is ignored; it is not queued, and in/shift are not re-sampled.
- result is the data register, visible in all states. It shows intermediate values during SHIFT. It is only guaranteed correct while done=1 and afterwards until the next accept.
- Shift amounts ≥ n (possible when 2^m-1 ≥ n) yield result=0. carry then equals the bit shifted out on the final cycle, which is 0 once the operand is exhausted.
- Width rule: result = (in << shift) mod 2^n. carry = in[n-shift] for 1≤shift≤n, else 0.

## Timing
- Latency: an accept at edge E0 with shift=k raises done after edge Ek, i.e. k cycles after E0. k=0 gives done high in the cycle immediately after E0.
- busy is high from the edge after E0 through edge Ek (k cycles total). busy=0 whenever done=1. busy is never asserted for k=0.
- done is high for exactly one cycle per accepted start.
- Throughput: one operation per k+1 cycles with back-to-back start (start asserted during DONE).
- Reset mid-operation, asynchronous:
  - Outputs clear without waiting for an edge; state returns to IDLE.
  - No done pulse is produced for the aborted operation.
  - start is honoured on the first edge after reset deasserts.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- in=16'h00FF, shift=0, start pulse -> done high in the cycle after E0, busy never high, result=16'h00FF, carry=0.
- in=16'hAAAA, shift=1 -> busy high 1 cycle, done after E1, result=16'h5554, carry=1.
- in=16'hF000, shift=3 -> busy high 3 cycles, done after E3, result=16'h8000, carry=1. Then issue a back-to-back start during DONE with in=16'h000F, shift=15 -> done 15 cycles later, result=16'h8000, carry=1.
- Busy ignore: in=16'h1234, shift=4 accepted. Pulse start with in=16'hFFFF, shift=1 two cycles later -> still one done, after E4, result=16'h2340, carry=1. No second done follows.
- Reset mid-op: in=16'h0F0F, shift=8, assert reset 3 cycles after accept -> busy/done/result/carry go to 0 immediately, no done pulse. After release, in=16'h0001, shift=2 -> done after E2, result=16'h0004, carry=0.
- Idle hold: after any completed operation, keep start=0 for 10 cycles -> result and carry stable, done=0, busy=0.
